// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
interface prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, in_data, input in_ready);
  modport slave  (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Byte-stream program loader for the 16x8 SAP program RAM; holds the CPU in clear while loading.
// Optional readback verify of the written block is enabled by defining PROG_LOADER_VERIFY_EN.
module prog_loader #(
  parameter int WORDS = 16
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  prog_loader_if.slave             stream,
  output logic [$clog2(WORDS)-1:0] ram_addr,
  output logic [7:0]               ram_wdata,
  output logic                     ram_we,
  input  logic [7:0]               ram_rdata,
  output logic                     cpu_clr,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int AW = $clog2(WORDS);

  typedef enum logic [2:0] {
    IDLE, HEADER, DATA, CSUM,
`ifdef PROG_LOADER_VERIFY_EN
    VERIFY,
`endif
    DONE, ERR
  } state_t;

  state_t         st, nxt;
  logic [AW-1:0]  addr;
  logic [3:0]     rem;
  logic [7:0]     sum;
  logic           beat;

  assign beat = stream.in_valid & stream.in_ready;
  assign done = (st == DONE);
  assign err  = (st == ERR);

`ifdef PROG_LOADER_VERIFY_EN
  logic [AW-1:0] vaddr;
  logic [4:0]    vn, vcnt;
  logic [7:0]    vsum;

  assign busy = (st == HEADER) || (st == DATA) || (st == CSUM) || (st == VERIFY);

  // Readback of address k lands one cycle later, so accumulate on vcnt 1..N and decide on N+1.
  always_ff @(posedge clk) begin
    if (clr) begin
      vaddr <= '0;
      vn    <= '0;
      vcnt  <= '0;
      vsum  <= '0;
    end else begin
      if (st == HEADER && beat) begin
        vaddr <= AW'(stream.in_data[7:4]);
        vn    <= {1'b0, stream.in_data[3:0]} + 5'd1;
      end
      if (st == CSUM && beat) begin
        vcnt <= '0;
        vsum <= '0;
      end
      if (st == VERIFY) begin
        vcnt  <= vcnt + 5'd1;
        vaddr <= vaddr + 1'b1;
        if (vcnt != 5'd0 && vcnt <= vn) vsum <= vsum + ram_rdata;
      end
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
  assign busy = (st == HEADER) || (st == DATA) || (st == CSUM);
`endif

  always_comb begin
    nxt             = st;
    stream.in_ready = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = '0;
    ram_wdata       = '0;
    case (st)
      IDLE, DONE, ERR: if (start) nxt = HEADER;
      HEADER: begin
        stream.in_ready = 1'b1;
        if (stream.in_valid) nxt = DATA;
      end
      DATA: begin
        stream.in_ready = 1'b1;
        ram_we          = stream.in_valid;
        ram_addr        = addr;
        ram_wdata       = stream.in_data;
        if (stream.in_valid && rem == 4'd0) nxt = CSUM;
      end
      CSUM: begin
        stream.in_ready = 1'b1;
        if (stream.in_valid) begin
`ifdef PROG_LOADER_VERIFY_EN
          nxt = (stream.in_data == sum) ? VERIFY : ERR;
`else
          nxt = (stream.in_data == sum) ? DONE : ERR;
`endif
        end
      end
`ifdef PROG_LOADER_VERIFY_EN
      VERIFY: begin
        ram_addr = vaddr;
        if (vcnt == vn + 5'd1) nxt = (vsum == sum) ? DONE : ERR;
      end
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      st      <= IDLE;
      cpu_clr <= 1'b0;
      addr    <= '0;
      rem     <= '0;
      sum     <= '0;
    end else begin
      st      <= nxt;
      cpu_clr <= (nxt != IDLE) && (nxt != DONE);
      if (st == HEADER && beat) begin
        addr <= AW'(stream.in_data[7:4]);
        rem  <= stream.in_data[3:0];
        sum  <= '0;
      end
      if (st == DATA && beat) begin
        addr <= addr + 1'b1;
        rem  <= rem - 4'd1;
        sum  <= sum + stream.in_data;
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: 16x8 RAM model, hand-computed streams, status and RAM checks.
module tb_prog_loader;
  logic       clk = 0;
  logic       clr, start;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic       ram_we, cpu_clr, busy, done, err;
  logic [7:0] mem [16];
  logic       corrupt = 0;
  int         n_chk = 0, n_pass = 0;

  prog_loader_if sif ();

  prog_loader #(.WORDS(16)) dut (
    .clk(clk), .clr(clr), .start(start), .stream(sif),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .cpu_clr(cpu_clr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous RAM; corrupt flips RAM[1] on readback only.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= (corrupt && ram_addr == 4'd1) ? ~mem[ram_addr] : mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk); start = 1;
    @(posedge clk); #1 start = 0;
    chk({tag, ".start"}, {sif.in_ready, cpu_clr, busy, done, err}, 5'b11100);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk); sif.in_valid = 1; sif.in_data = b;
    @(posedge clk); #1 sif.in_valid = 0;
  endtask

  // Full session: header, n data bytes, checksum; checks the final status.
  task automatic load(input string tag, input logic [7:0] hdr,
                      input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3,
                      input int n, input logic [7:0] cs, input logic ok);
    logic [7:0] d [4];
    d = '{d0, d1, d2, d3};
    pulse_start(tag);
    send(hdr);
    for (int i = 0; i < n; i++) send(d[i]);
    @(negedge clk); sif.in_valid = 1; sif.in_data = cs;
    chk({tag, ".pre"}, {done, err}, 2'b00);
    @(posedge clk); #1 sif.in_valid = 0;
`ifdef PROG_LOADER_VERIFY_EN
    if (dut.st != dut.ERR) begin
      repeat (n + 1) @(posedge clk);
      #1 chk({tag, ".vfy"}, {done, err, busy}, 3'b001);
      @(posedge clk); #1;
    end
`endif
    chk({tag, ".res"}, {done, err, cpu_clr, busy}, ok ? 4'b1000 : 4'b0110);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    clr = 1; start = 0; sif.in_valid = 0; sif.in_data = 0;
    repeat (3) @(posedge clk);
    #1 chk("reset", {sif.in_ready, ram_we, ram_addr, ram_wdata, cpu_clr, busy, done, err}, 0);
    @(negedge clk); clr = 0;

    // Data words at 14/15
    load("a", 8'hE1, 8'h38, 8'h23, 8'h00, 8'h00, 2, 8'h5B, 1);
    chk("a.m14", mem[14], 8'h38);
    chk("a.m15", mem[15], 8'h23);

    // Program LDA 14 / ADD 15 / OUT / HLT
    load("b", 8'h03, 8'h1E, 8'h2F, 8'hE0, 8'hF0, 4, 8'h1D, 1);
    chk("b.prog", {mem[0], mem[1], mem[2], mem[3]}, 32'h1E2FE0F0);
    chk("b.out", mem[mem[0][3:0]] + mem[mem[1][3:0]], 8'h5B);

    // Address wrap 15 -> 0
    load("c", 8'hF1, 8'h11, 8'h22, 8'h00, 8'h00, 2, 8'h33, 1);
    chk("c.wrap", {mem[15], mem[0]}, 16'h1122);

    // Bad checksum, then recover
    load("d", 8'hE1, 8'h38, 8'h23, 8'h00, 8'h00, 2, 8'h00, 0);
    load("d2", 8'hE1, 8'h38, 8'h23, 8'h00, 8'h00, 2, 8'h5B, 1);

    // Stall in DATA, then clr mid-session
    pulse_start("e");
    send(8'h42);
    send(8'h01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("e.stall", {ram_we, ram_addr}, {1'b0, 4'd5});
    end
    send(8'h02);
    chk("e.mem", {mem[4], mem[5]}, 16'h0102);
    @(negedge clk); clr = 1;
    @(posedge clk); #1;
    chk("e.clr", {sif.in_ready, ram_we, ram_addr, ram_wdata, cpu_clr, busy, done, err}, 0);
    @(negedge clk); clr = 0;
    chk("e.keep", {mem[4], mem[5]}, 16'h0102);

`ifdef PROG_LOADER_VERIFY_EN
    // Readback sees RAM[1] corrupted -> ERR
    corrupt = 1;
    load("f", 8'h01, 8'hAA, 8'h55, 8'h00, 8'h00, 2, 8'hFF, 0);
    corrupt = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
# prog_loader

Hardware program loader for the 8-bit SAP-style computer. It accepts a byte stream over a valid/ready handshake and writes it into the 16×8 program RAM, holding the CPU in clear while it loads. It checks a trailing checksum and then releases the CPU so execution starts from address 0. It sits between an external byte source (host or UART receiver) and the RAM write port, replacing direct bench pokes into RAM.

## Interface
- `WORDS`, default 16: RAM depth; address width is 4.
- `clk`  in  1  system clock; every transition happens on its rising edge.
- `clr`  in  1  reset; synchronous, active-high.
- `start`  in  1  single-cycle pulse; begins a load session from IDLE, DONE or ERR.
- `in_valid`  in  1  source has a byte on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `ram_addr`  out  4  RAM address, for both write and readback.
- `ram_wdata`  out  8  RAM write data.
- `ram_we`  out  1  RAM write strobe; RAM captures on the rising edge of `clk`.
- `ram_rdata`  in  8  RAM read data; valid one cycle after `ram_addr` is presented.
- `cpu_clr`  out  1  holds the CPU in clear.
- `busy`  out  1  a load session is in progress.
- `done`  out  1  the last session succeeded.
- `err`  out  1  the last session failed.

## Operation
- A byte transfers when `in_valid & in_ready` at the rising edge of `clk`.
- Stream format:
  - Header byte `{base[7:4], cnt_m1[3:0]}`.
  - Then `cnt_m1+1` data bytes.
  - Then one checksum byte.
- States: IDLE, HEADER, DATA, CSUM, VERIFY (present only when the macro is defined), DONE, ERR.
- IDLE
  - `cpu_clr=0`; the CPU runs the current RAM contents.
  - `start` moves to HEADER.
- HEADER
  - `cpu_clr=1`, `busy=1`, `in_ready=1`.
  - On a beat: latch `base` into the address counter, `cnt_m1` into the remaining counter, clear `sum`, go to DATA.
- DATA
  - `in_ready=1`.
  - `ram_we = in_valid` (combinational), `ram_addr` = address counter, `ram_wdata = in_data`.
  - Each beat: address counter increments modulo 16 (15 wraps to 0), `sum += in_data` (mod 256), remaining counter decrements.
  - The beat that arrives with remaining count 0 moves to CSUM.
- CSUM
  - On a beat, compare `in_data` with `sum`.
  - Equal: go to VERIFY if compiled in, else DONE.
  - Not equal: go to ERR.
- DONE: `cpu_clr=0`, `done=1`, `busy=0`; the CPU starts from PC=0.
- ERR: `cpu_clr=1`, `err=1`, `busy=0`; the CPU stays halted.
- From DONE or ERR, `start` clears `done`/`err` and enters HEADER.
- `start` is ignored while `busy=1`.
- `ram_we` is 0 in every state except DATA.

## Timing
- `clr` forces the state to IDLE on the next edge, including in the middle of a session. RAM contents already written are not undone.
- Reset values: `in_ready=0`, `ram_we=0`, `ram_addr=0`, `ram_wdata=0`, `cpu_clr=0`, `busy=0`, `done=0`, `err=0`.
- Latencies:
  - `start` → `in_ready=1` and `cpu_clr=1`: 1 cycle.
  - Data beat → RAM written: same edge (0 latency).
  - Checksum beat → `done`/`err` asserted: 1 cycle without verify.
  - With verify: `N+2` cycles from the checksum beat.
- One byte per cycle with `in_valid` held high; `in_valid` low stalls indefinitely with no timeout.
- `cnt_m1=15` with `base≠0` wraps, and writes all 16 locations.
- `cpu_clr` is glitch-free: registered from the state.

## Configuration
- `PROG_LOADER_VERIFY_EN` defined:
  - After a good checksum, VERIFY re-reads the N locations from `base`, one address per cycle, with `in_ready=0`.
  - It sums `ram_rdata` using the 1-cycle read latency.
  - Readback sum equal to the checksum → DONE; otherwise → ERR.
- Undefined: the VERIFY state and its readback logic are absent, and CSUM goes straight to DONE or ERR.

## Test plan
- Stream `0xE1, 0x38, 0x23, 0x5B`:
  - RAM[14]=0x38, RAM[15]=0x23, `done=1`, `cpu_clr` falls.
- Stream `0x03, 0x1E, 0x2F, 0xE0, 0xF0, 0x1D`, then release: RAM[0..3] hold LDA 14 / ADD 15 / OUT / HLT; with RAM[14]=0x38 and RAM[15]=0x23 already loaded, the CPU displays 0x5B.
- Header `0xF1`, data `0x11, 0x22`: writes RAM[15] then RAM[0] (wrap); checksum `0x33` → `done=1`.
- Bad checksum (`0x00` instead of `0x5B` in the first scenario): `err=1`, `cpu_clr` stays 1; a later `start` followed by a good stream → `done=1`.
- Hold `in_valid` low for 5 cycles in the middle of DATA: no `ram_we`, no address advance. Assert `clr` in the middle of DATA: IDLE next cycle with all outputs at reset values.
- Verify build: force RAM[1] corrupt during VERIFY → `err=1`. Non-verify build: `done` exactly 1 cycle after the checksum beat.
